// File: rtl/turbo_pkg.sv
// Shared trellis definition for the 8-state RSC constituent code.
// Encoder, decoder and interleaver benches all derive branches from these helpers.
package turbo_pkg;

    localparam int NUM_STATES  = 8;
    localparam int MEM         = 3;
    localparam int PM_INIT_INF = 16;

    typedef logic [MEM-1:0] rsc_state_t;

    typedef enum logic [1:0] {
        ST_ACS   = 2'd0,
        ST_TRACE = 2'd1,
        ST_OUT   = 2'd2
    } dec_state_e;

    // State layout is {d1,d2,d3}; a is the feedback bit entering the register.
    function automatic rsc_state_t rsc_next_state(input rsc_state_t s, input logic u);
        logic a;
        a = u ^ s[1] ^ s[0];
        return {a, s[2], s[1]};
    endfunction

    function automatic logic rsc_parity(input rsc_state_t s, input logic u);
        logic a;
        a = u ^ s[1] ^ s[0];
        return a ^ s[2] ^ s[0];
    endfunction

    function automatic rsc_state_t rsc_pred(input rsc_state_t n, input logic d3);
        return {n[1], n[0], d3};
    endfunction

endpackage

// File: rtl/rsc_acs_unit.sv
// Eight parallel add-compare-select cells with min-normalization of the new metrics.
// Purely combinational, zero latency.
// No flow control; the caller decides when the results are committed.
module rsc_acs_unit
    import turbo_pkg::*;
#(
    parameter int PM_W = 8
) (
    input  logic [NUM_STATES-1:0][PM_W-1:0] pm_in,
    input  logic                            xk,
    input  logic                            zk,
    output logic [NUM_STATES-1:0][PM_W-1:0] pm_out,
    output logic [NUM_STATES-1:0]           dec,
    output logic [PM_W-1:0]                 pm_min
);

    logic [NUM_STATES-1:0][PM_W-1:0] cand0;
    logic [NUM_STATES-1:0][PM_W-1:0] cand1;
    logic [NUM_STATES-1:0][PM_W-1:0] pm_sel;

    function automatic logic [1:0] branch_bm(input rsc_state_t n, input logic d3,
                                             input logic rx_x, input logic rx_z);
        rsc_state_t p;
        logic       u;
        p = rsc_pred(n, d3);
        u = n[2] ^ n[0] ^ d3;
        return {1'b0, rx_x ^ u} + {1'b0, rx_z ^ rsc_parity(p, u)};
    endfunction

    // Saturate rather than wrap so an unreachable state can never look cheap.
    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm, input logic [1:0] bm);
        logic [PM_W:0] s;
        s = {1'b0, pm} + (PM_W+1)'(bm);
        return s[PM_W] ? '1 : s[PM_W-1:0];
    endfunction

    always_comb begin
        cand0 = '0;
        cand1 = '0;
        for (int n = 0; n < NUM_STATES; n++) begin
            cand0[n] = sat_add(pm_in[rsc_pred(3'(n), 1'b0)], branch_bm(3'(n), 1'b0, xk, zk));
            cand1[n] = sat_add(pm_in[rsc_pred(3'(n), 1'b1)], branch_bm(3'(n), 1'b1, xk, zk));
        end
    end

    always_comb begin
        pm_sel = '0;
        dec    = '0;
        for (int n = 0; n < NUM_STATES; n++) begin
            dec[n]    = cand1[n] < cand0[n];
            pm_sel[n] = dec[n] ? cand1[n] : cand0[n];
        end
    end

    always_comb begin
        pm_min = pm_sel[0];
        for (int n = 1; n < NUM_STATES; n++) begin
            if (pm_sel[n] < pm_min) pm_min = pm_sel[n];
        end
    end

    always_comb begin
        pm_out = '0;
        for (int n = 0; n < NUM_STATES; n++) begin
            pm_out[n] = pm_sel[n] - pm_min;
        end
    end

endmodule

// File: rtl/rsc_viterbi_decoder.sv
// Hard-decision Viterbi decoder for the 8-state RSC code, traceback from state 0.
// First out_valid K+3 cycles after the last (K+3)-th input handshake.
// in_ready drops during traceback/output; outputs hold while out_ready is low.
module rsc_viterbi_decoder
    import turbo_pkg::*;
#(
    parameter int K     = 40,
    parameter int PM_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             xk,
    input  logic             zk,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_last,
    output logic [CNT_W-1:0] out_metric
);

    localparam int IDX_W = $clog2(K + 3);
    localparam int OB_W  = $clog2(K);
    localparam logic [IDX_W-1:0] LAST_STEP = IDX_W'(K + 2);
    localparam logic [IDX_W-1:0] LAST_OUT  = IDX_W'(K - 1);
    localparam logic [IDX_W-1:0] K_IDX     = IDX_W'(K);
    localparam logic [NUM_STATES-1:0][PM_W-1:0] PM_RST =
        {{(NUM_STATES-1){PM_W'(PM_INIT_INF)}}, PM_W'(0)};

    dec_state_e                      state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    rsc_state_t                      tb_st_q, tb_st_d;
    logic [NUM_STATES-1:0][PM_W-1:0] pm_q, pm_d;
    logic [CNT_W-1:0]                norm_acc_q, norm_acc_d;
    logic [K-1:0]                    obuf_q, obuf_d;
    logic [NUM_STATES-1:0]           surv_mem [K+3];

    logic [NUM_STATES-1:0][PM_W-1:0] acs_pm;
    logic [NUM_STATES-1:0]           acs_dec;
    logic [PM_W-1:0]                 acs_min;
    logic                            acs_go;
    logic                            surv_we;
    logic                            tb_dec;
    logic [CNT_W:0]                  norm_sum;
    logic [CNT_W:0]                  metric_sum;

    rsc_acs_unit #(.PM_W(PM_W)) u_acs (
        .pm_in  (pm_q),
        .xk     (xk),
        .zk     (zk),
        .pm_out (acs_pm),
        .dec    (acs_dec),
        .pm_min (acs_min)
    );

    assign acs_go = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (clr) state_q <= ST_ACS;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACS:   if (acs_go && idx_q == LAST_STEP) state_d = ST_TRACE;
            ST_TRACE: if (idx_q == '0) state_d = ST_OUT;
            ST_OUT:   if (out_ready && idx_q == LAST_OUT) state_d = ST_ACS;
            default:  state_d = ST_ACS;
        endcase
    end

    always_comb begin
        metric_sum = {1'b0, norm_acc_q} + (CNT_W+1)'(pm_q[0]);
        in_ready   = state_q == ST_ACS;
        out_valid  = state_q == ST_OUT;
        out_bit    = out_valid & obuf_q[idx_q[OB_W-1:0]];
        out_last   = out_valid & (idx_q == LAST_OUT);
        out_metric = '0;
        if (out_valid) out_metric = metric_sum[CNT_W] ? '1 : metric_sum[CNT_W-1:0];
    end

    always_comb begin
        idx_d      = idx_q;
        tb_st_d    = tb_st_q;
        pm_d       = pm_q;
        norm_acc_d = norm_acc_q;
        obuf_d     = obuf_q;
        surv_we    = 1'b0;
        tb_dec     = surv_mem[idx_q][tb_st_q];
        norm_sum   = {1'b0, norm_acc_q} + (CNT_W+1)'(acs_min);
        case (state_q)
            ST_ACS: begin
                if (acs_go) begin
                    pm_d       = acs_pm;
                    norm_acc_d = norm_sum[CNT_W] ? '1 : norm_sum[CNT_W-1:0];
                    surv_we    = 1'b1;
                    if (idx_q == LAST_STEP) tb_st_d = '0;
                    else                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_TRACE: begin
                // Tail steps steer the path back to state 0 but are not data.
                if (idx_q < K_IDX) obuf_d[idx_q[OB_W-1:0]] = tb_st_q[2] ^ tb_st_q[0] ^ tb_dec;
                tb_st_d = rsc_pred(tb_st_q, tb_dec);
                if (idx_q != '0) idx_d = idx_q - IDX_W'(1);
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (idx_q == LAST_OUT) begin
                        idx_d      = '0;
                        pm_d       = PM_RST;
                        norm_acc_d = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            idx_q      <= '0;
            tb_st_q    <= '0;
            pm_q       <= PM_RST;
            norm_acc_q <= '0;
            obuf_q     <= '0;
        end else begin
            idx_q      <= idx_d;
            tb_st_q    <= tb_st_d;
            pm_q       <= pm_d;
            norm_acc_q <= norm_acc_d;
            obuf_q     <= obuf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (surv_we) surv_mem[idx_q] <= acs_dec;
    end

endmodule
